// File: rtl/vga_to_axis.sv
// Parallel video (data/hde/vde) to AXI4-Stream master.
// Captured pixels pass through a one-word hold stage, which looks one cycle
// ahead to detect the end of a line (TLAST), and then into a synchronous FIFO
// that absorbs downstream back-pressure. Video cannot be stalled, so a word
// that meets a full FIFO is lost and the rest of that frame is discarded.
module vga_to_axis #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 1024,
    parameter int H_ACTIVE   = 640
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] vid_data_i,
    input  logic                  vid_hde_i,
    input  logic                  vid_vde_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow_o,
    output logic                  line_err_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_WIDTH + 2;   // {sof, eol, data}

    typedef enum logic [1:0] {WAIT_BLANK, ARMED, ACTIVE, DROP} state_t;

    state_t                  state_reg, state_next;
    logic                    hold_valid_reg;
    logic [DATA_WIDTH-1:0]   hold_data_reg;
    logic                    hold_sof_reg;
    logic [AW:0]             wr_ptr_reg, rd_ptr_reg;
    logic [WW-1:0]           mem [FIFO_DEPTH];
    logic [WW-1:0]           rd_word;
    logic [15:0]             line_cnt_reg;
    logic [15:0]             frame_cnt_reg;
    logic                    overflow_reg, line_err_reg;

    logic px, fifo_empty, fifo_full, pop, push, ovf_now, eol_write;
    logic capture, capture_sof, frame_done;

    assign px         = vid_hde_i & vid_vde_i;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    assign pop        = !fifo_empty && m_axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = hold_valid_reg && (!fifo_full || pop);
    assign ovf_now    = hold_valid_reg && fifo_full && !pop;
    // The held pixel ends a line when no pixel follows it this cycle.
    assign eol_write  = push && !px;

    // Capture FSM: state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= WAIT_BLANK;
        else         state_reg <= state_next;
    end

    // Capture FSM: next state, capture strobe and frame-complete strobe.
    always_comb begin
        state_next  = state_reg;
        capture     = 1'b0;
        capture_sof = 1'b0;
        frame_done  = 1'b0;
        case (state_reg)
            WAIT_BLANK: if (!vid_vde_i) state_next = ARMED;
            ARMED: begin
                if (px) begin
                    capture     = 1'b1;
                    capture_sof = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ovf_now) begin
                    state_next = DROP;
                end else if (!vid_vde_i) begin
                    frame_done = 1'b1;
                    state_next = ARMED;
                end else if (px) begin
                    capture = 1'b1;
                end
            end
            DROP:    if (!vid_vde_i) state_next = ARMED;
            default: state_next = WAIT_BLANK;
        endcase
    end

    // Hold stage: one captured pixel plus its SOF flag, drained next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_sof_reg   <= 1'b0;
        end else begin
            hold_valid_reg <= capture;
            if (capture) begin
                hold_data_reg <= vid_data_i;
                hold_sof_reg  <= capture_sof;
            end
        end
    end

    // FIFO storage: plain array, no reset, so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= {hold_sof_reg, !px, hold_data_reg};
    end

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Line length counter: counts captured pixels, restarts at every EOL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  line_cnt_reg <= '0;
        else if (ovf_now || eol_write) line_cnt_reg <= '0;
        else if (capture)             line_cnt_reg <= line_cnt_reg + 16'd1;
    end

    // Status: sticky flags (a set beats a same-cycle clear) and frame counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_reg  <= 1'b0;
            line_err_reg  <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (ovf_now)      overflow_reg <= 1'b1;
            else if (clear_i) overflow_reg <= 1'b0;
            if (eol_write && (line_cnt_reg != 16'(H_ACTIVE))) line_err_reg <= 1'b1;
            else if (clear_i)                                 line_err_reg <= 1'b0;
            if (frame_done) frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    // First-word-fall-through output; payload forced to zero while empty.
    assign rd_word       = mem[rd_ptr_reg[AW-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : rd_word[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !fifo_empty && rd_word[DATA_WIDTH];
    assign m_axis_tuser  = !fifo_empty && rd_word[DATA_WIDTH+1];
    assign overflow_o    = overflow_reg;
    assign line_err_o    = line_err_reg;
    assign frame_cnt_o   = frame_cnt_reg;

endmodule
